// File: rtl/mem_tag_arbiter.sv
// mem_tag_arbiter: shares a single tagged memory command port between an
// icache (reads only) and a dcache (reads and writes).
// Each command is issued through the states IDLE -> CMD, plus WDATA for writes.
// Refill beats are steered back to their requester by tag bit 0.
// Ports:
//   clk, reset            - clock and asynchronous active-low reset
//   ic_req_* / ic_resp_*  - icache read request and refill beat strobe
//   dc_req_* / dc_resp_*  - dcache request (rw=1 write) and refill beat strobe
//   dc_data_valid/ready   - dcache write-data handshake (data bits bypass)
//   mem_req_*             - memory command (addr, rw, tag)
//   mem_data_valid/ready  - memory write-data handshake
//   mem_resp_valid/tag    - memory response beat
module mem_tag_arbiter #(
    parameter int unsigned ADDR_BITS = 28,
    parameter int unsigned TAG_BITS  = 5,
    parameter int unsigned BEATS     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ic_req_valid,
    output logic                 ic_req_ready,
    input  logic [ADDR_BITS-1:0] ic_req_addr,
    output logic                 ic_resp_valid,
    input  logic                 dc_req_valid,
    output logic                 dc_req_ready,
    input  logic                 dc_req_rw,
    input  logic [ADDR_BITS-1:0] dc_req_addr,
    input  logic                 dc_data_valid,
    output logic                 dc_data_ready,
    output logic                 dc_resp_valid,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic                 mem_req_rw,
    output logic [ADDR_BITS-1:0] mem_req_addr,
    output logic [TAG_BITS-1:0]  mem_req_tag,
    output logic                 mem_data_valid,
    input  logic                 mem_data_ready,
    input  logic                 mem_resp_valid,
    input  logic [TAG_BITS-1:0]  mem_resp_tag
);

    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CMD   = 2'd1,
        S_WDATA = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic                   src_q, src_d;       // 0 = ic, 1 = dc
    logic                   rw_q, rw_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic                   rr_q, rr_d;         // source accepted last
    logic                   ic_busy_q, ic_busy_d;
    logic                   dc_busy_q, dc_busy_d;
    logic [CNT_W-1:0]       ic_cnt_q, ic_cnt_d;
    logic [CNT_W-1:0]       dc_cnt_q, dc_cnt_d;
    logic [CNT_W-1:0]       wcnt_q, wcnt_d;

    logic in_cmd, in_wdata, ic_elig, dc_elig, grant_dc, read_accept;
    logic unused_tag_bits;

    // Upper tag bits are not needed for steering; only bit 0 selects the source.
    assign unused_tag_bits = ^mem_resp_tag;

    assign in_cmd   = (state_q == S_CMD);
    assign in_wdata = (state_q == S_WDATA);

    // Command and handshake outputs decode straight from the held state.
    assign mem_req_valid  = in_cmd;
    assign mem_req_rw     = rw_q;
    assign mem_req_addr   = addr_q;
    assign mem_req_tag    = TAG_BITS'(src_q);
    assign ic_req_ready   = in_cmd & ~src_q & mem_req_ready;
    assign dc_req_ready   = in_cmd &  src_q & mem_req_ready;
    assign mem_data_valid = in_wdata & dc_data_valid;
    assign dc_data_ready  = in_wdata & mem_data_ready;

    // Beats for a source that has no refill outstanding are silently dropped.
    assign ic_resp_valid = mem_resp_valid & ~mem_resp_tag[0] & ic_busy_q;
    assign dc_resp_valid = mem_resp_valid &  mem_resp_tag[0] & dc_busy_q;

    assign ic_elig     = ic_req_valid & ~ic_busy_q;
    assign dc_elig     = dc_req_valid & ~dc_busy_q;
    // On a tie, give the grant to whoever was not accepted last.
    assign grant_dc    = dc_elig & (~ic_elig | ~rr_q);
    assign read_accept = in_cmd & mem_req_ready & ~rw_q;

    // Next-state logic: command FSM plus independent refill beat tracking.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        rr_d      = rr_q;
        ic_busy_d = ic_busy_q;
        dc_busy_d = dc_busy_q;
        ic_cnt_d  = ic_cnt_q;
        dc_cnt_d  = dc_cnt_q;
        wcnt_d    = wcnt_q;

        case (state_q)
            S_IDLE: begin
                if (ic_elig || dc_elig) begin
                    src_d   = grant_dc;
                    addr_d  = grant_dc ? dc_req_addr : ic_req_addr;
                    rw_d    = grant_dc & dc_req_rw;
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                if (mem_req_ready) begin
                    rr_d = src_q;
                    if (rw_q) begin
                        wcnt_d  = '0;
                        state_d = S_WDATA;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_WDATA: begin
                if (dc_data_valid && mem_data_ready) begin
                    if (wcnt_q == LAST_BEAT) begin
                        wcnt_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        wcnt_d = wcnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (ic_resp_valid) begin
            if (ic_cnt_q == LAST_BEAT) begin
                ic_cnt_d  = '0;
                ic_busy_d = 1'b0;
            end else begin
                ic_cnt_d = ic_cnt_q + CNT_W'(1);
            end
        end

        if (dc_resp_valid) begin
            if (dc_cnt_q == LAST_BEAT) begin
                dc_cnt_d  = '0;
                dc_busy_d = 1'b0;
            end else begin
                dc_cnt_d = dc_cnt_q + CNT_W'(1);
            end
        end

        // A source in CMD is never busy, so this cannot collide with a beat clear.
        if (read_accept) begin
            if (src_q) begin
                dc_busy_d = 1'b1;
            end else begin
                ic_busy_d = 1'b1;
            end
        end
    end

    // State register; rr resets to dc so ic wins the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            src_q     <= 1'b0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            rr_q      <= 1'b1;
            ic_busy_q <= 1'b0;
            dc_busy_q <= 1'b0;
            ic_cnt_q  <= '0;
            dc_cnt_q  <= '0;
            wcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            rr_q      <= rr_d;
            ic_busy_q <= ic_busy_d;
            dc_busy_q <= dc_busy_d;
            ic_cnt_q  <= ic_cnt_d;
            dc_cnt_q  <= dc_cnt_d;
            wcnt_q    <= wcnt_d;
        end
    end

endmodule

// File: tb/tb_mem_tag_arbiter.sv
// Self-checking bench for mem_tag_arbiter: directed vector table, hand-built
// multi-cycle sequences and randomized traffic checked against a behavioural model.
module tb_mem_tag_arbiter;

    localparam int unsigned AW = 28;
    localparam int unsigned TW = 5;
    localparam int unsigned NB = 4;

    logic          clk;
    logic          reset;
    logic          ic_req_valid, ic_req_ready, ic_resp_valid;
    logic [AW-1:0] ic_req_addr;
    logic          dc_req_valid, dc_req_ready, dc_req_rw, dc_resp_valid;
    logic [AW-1:0] dc_req_addr;
    logic          dc_data_valid, dc_data_ready;
    logic          mem_req_valid, mem_req_ready, mem_req_rw;
    logic [AW-1:0] mem_req_addr;
    logic [TW-1:0] mem_req_tag;
    logic          mem_data_valid, mem_data_ready;
    logic          mem_resp_valid;
    logic [TW-1:0] mem_resp_tag;

    mem_tag_arbiter #(.ADDR_BITS(AW), .TAG_BITS(TW), .BEATS(NB)) dut (
        .clk            (clk),
        .reset          (reset),
        .ic_req_valid   (ic_req_valid),
        .ic_req_ready   (ic_req_ready),
        .ic_req_addr    (ic_req_addr),
        .ic_resp_valid  (ic_resp_valid),
        .dc_req_valid   (dc_req_valid),
        .dc_req_ready   (dc_req_ready),
        .dc_req_rw      (dc_req_rw),
        .dc_req_addr    (dc_req_addr),
        .dc_data_valid  (dc_data_valid),
        .dc_data_ready  (dc_data_ready),
        .dc_resp_valid  (dc_resp_valid),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_rw     (mem_req_rw),
        .mem_req_addr   (mem_req_addr),
        .mem_req_tag    (mem_req_tag),
        .mem_data_valid (mem_data_valid),
        .mem_data_ready (mem_data_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_tag   (mem_resp_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Behavioural model: phase 0 = idle, 1 = command offered, 2 = write data.
    int            m_phase;
    logic          m_src, m_rw, m_rr;
    logic [AW-1:0] m_addr;
    logic          m_busy [2];
    int            m_left [2];
    int            m_wleft;

    // Outputs as observed in the most recent cycle.
    logic          l_mrv, l_mrw, l_icr, l_dcr, l_icrs, l_dcrs, l_mdv, l_ddr;
    logic [TW-1:0] l_tag;
    logic [AW-1:0] l_addr;

    typedef struct packed {
        logic [7:0]    in;    // icv dcv dcrw ddv mrr mdr rv rtag0
        logic [7:0]    ex;    // mrv tag0 icr dcr icrs dcrs mdv ddr
        logic [AW-1:0] addr;  // expected command address when mrv=1
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [40:0] outs();
        return {ic_req_ready, ic_resp_valid, dc_req_ready, dc_data_ready, dc_resp_valid,
                mem_req_valid, mem_data_valid, mem_req_rw, mem_req_tag, mem_req_addr};
    endfunction

    task automatic clr_in();
        ic_req_valid   = 1'b0;
        ic_req_addr    = '0;
        dc_req_valid   = 1'b0;
        dc_req_rw      = 1'b0;
        dc_req_addr    = '0;
        dc_data_valid  = 1'b0;
        mem_req_ready  = 1'b0;
        mem_data_ready = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_tag   = '0;
    endtask

    task automatic model_reset();
        m_phase   = 0;
        m_src     = 1'b0;
        m_rw      = 1'b0;
        m_rr      = 1'b1;
        m_addr    = '0;
        m_busy[0] = 1'b0;
        m_busy[1] = 1'b0;
        m_left[0] = 0;
        m_left[1] = 0;
        m_wleft   = 0;
    endtask

    // Called at a falling edge with inputs already set; checks, advances, returns at next falling edge.
    task automatic cyc();
        logic [40:0] a, e, msk;
        logic e_mrv, e_icr, e_dcr, e_ddr, e_mdv, e_icrs, e_dcrs, ic_el, dc_el;
        #1;
        a      = outs();
        l_mrv  = mem_req_valid;
        l_mrw  = mem_req_rw;
        l_tag  = mem_req_tag;
        l_addr = mem_req_addr;
        l_icr  = ic_req_ready;
        l_dcr  = dc_req_ready;
        l_icrs = ic_resp_valid;
        l_dcrs = dc_resp_valid;
        l_mdv  = mem_data_valid;
        l_ddr  = dc_data_ready;

        e_mrv  = (m_phase == 1);
        e_icr  = e_mrv && !m_src && mem_req_ready;
        e_dcr  = e_mrv && m_src && mem_req_ready;
        e_ddr  = (m_phase == 2) && mem_data_ready;
        e_mdv  = (m_phase == 2) && dc_data_valid;
        e_icrs = mem_resp_valid && !mem_resp_tag[0] && m_busy[0];
        e_dcrs = mem_resp_valid && mem_resp_tag[0] && m_busy[1];
        e   = {e_icr, e_icrs, e_dcr, e_ddr, e_dcrs, e_mrv, e_mdv, m_rw, TW'(m_src), m_addr};
        msk = e_mrv ? '1 : {7'h7f, 34'h0};
        check("model_outputs", 64'(a & msk), 64'(e & msk));

        ic_el = ic_req_valid && !m_busy[0];
        dc_el = dc_req_valid && !m_busy[1];
        if (e_icrs) begin
            m_left[0] = m_left[0] - 1;
            if (m_left[0] == 0) m_busy[0] = 1'b0;
        end
        if (e_dcrs) begin
            m_left[1] = m_left[1] - 1;
            if (m_left[1] == 0) m_busy[1] = 1'b0;
        end
        case (m_phase)
            0: if (ic_el || dc_el) begin
                m_src   = dc_el && (!ic_el || !m_rr);
                m_addr  = m_src ? dc_req_addr : ic_req_addr;
                m_rw    = m_src ? dc_req_rw : 1'b0;
                m_phase = 1;
            end
            1: if (mem_req_ready) begin
                m_rr = m_src;
                if (m_rw) begin
                    m_phase = 2;
                    m_wleft = NB;
                end else begin
                    m_busy[m_src] = 1'b1;
                    m_left[m_src] = NB;
                    m_phase       = 0;
                end
            end
            default: if (dc_data_valid && mem_data_ready) begin
                m_wleft = m_wleft - 1;
                if (m_wleft == 0) m_phase = 0;
            end
        endcase
        @(negedge clk);
    endtask

    // Called at a falling edge; holds reset across one rising edge.
    task automatic do_reset();
        reset = 1'b0;
        clr_in();
        #1;
        check("reset_outputs", 64'(outs()), 64'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        int k, hs, pulses;
        logic ic_p, dc_p, dc_prw, hs_ic, hs_dc;
        logic [AW-1:0] ic_a, dc_a;
        logic [4:0] wpat;

        tbl[0] = {8'b1100_1000, 8'b0000_0000, 28'h0000000};
        tbl[1] = {8'b1100_1000, 8'b1010_0000, 28'h0000100};
        tbl[2] = {8'b0100_1000, 8'b0000_0000, 28'h0000000};
        tbl[3] = {8'b0100_1000, 8'b1101_0000, 28'h0000ABC};
        tbl[4] = {8'b0000_0011, 8'b0000_0100, 28'h0000000};
        tbl[5] = {8'b0000_0010, 8'b0000_1000, 28'h0000000};
        tbl[6] = {8'b0111_0100, 8'b0000_0000, 28'h0000000};
        tbl[7] = {8'b1111_1110, 8'b0000_1000, 28'h0000000};

        reset = 1'b0;
        clr_in();
        model_reset();
        @(negedge clk);
        do_reset();

        // Directed table: tie goes to ic first, then dc; beats steer by tag bit 0.
        for (int r = 0; r < 8; r++) begin
            {ic_req_valid, dc_req_valid, dc_req_rw, dc_data_valid,
             mem_req_ready, mem_data_ready, mem_resp_valid, mem_resp_tag[0]} = tbl[r].in;
            mem_resp_tag[TW-1:1] = '0;
            ic_req_addr = 28'h0000100;
            dc_req_addr = 28'h0000ABC;
            cyc();
            check($sformatf("tbl%0d_flags", r),
                  64'({l_mrv, l_icr, l_dcr, l_icrs, l_dcrs, l_mdv, l_ddr}),
                  64'({tbl[r].ex[7], tbl[r].ex[5:0]}));
            if (tbl[r].ex[7]) begin
                check($sformatf("tbl%0d_addr", r), 64'(l_addr), 64'(tbl[r].addr));
                check($sformatf("tbl%0d_tag", r), 64'(l_tag), 64'(TW'(tbl[r].ex[6])));
            end
        end

        // Stale beats after reset must be dropped.
        do_reset();
        mem_resp_valid = 1'b1;
        mem_resp_tag   = 5'h00;
        cyc();
        check("stale_ic_beat", 64'(l_icrs), 64'd0);
        mem_resp_tag   = 5'h01;
        cyc();
        check("stale_dc_beat", 64'(l_dcrs), 64'd0);

        // A busy icache blocks its next request until the refill completes.
        do_reset();
        ic_req_valid = 1'b1; ic_req_addr = 28'h0001000; mem_req_ready = 1'b1;
        cyc();
        cyc();
        check("ic_first_accept", 64'(l_icr), 64'd1);
        ic_req_addr = 28'h0002000;
        pulses = 0;
        for (int j = 0; j < 5; j++) begin
            mem_resp_valid = (j != 2);
            mem_resp_tag   = '0;
            cyc();
            check("blocked_while_busy", 64'(l_mrv), 64'd0);
            if (l_icrs) pulses++;
        end
        check("ic_beats", 64'(pulses), 64'd4);
        mem_resp_valid = 1'b0;
        k = 0;
        for (int j = 0; j < 10; j++) begin
            cyc();
            k++;
            if (l_mrv) break;
        end
        check("ic_reissue_latency", 64'(k), 64'd2);
        check("ic_reissue_addr", 64'(l_addr), 64'h0002000);
        ic_req_valid = 1'b0;

        // dcache write burst with a stalling memory data port.
        do_reset();
        dc_req_valid = 1'b1; dc_req_rw = 1'b1; dc_req_addr = 28'h0000ABC;
        dc_data_valid = 1'b1; mem_req_ready = 1'b1;
        cyc();
        cyc();
        check("wr_accept", 64'({l_dcr, l_mrw, l_tag}), 64'({1'b1, 1'b1, 5'h01}));
        dc_req_valid = 1'b0;
        wpat = 5'b11101;
        hs = 0;
        for (int j = 0; j < 5; j++) begin
            mem_data_ready = wpat[j];
            cyc();
            if (l_ddr && dc_data_valid) hs++;
        end
        check("wr_handshakes", 64'(hs), 64'd4);
        mem_data_ready = 1'b1;
        cyc();
        check("wr_back_idle", 64'({l_ddr, l_mdv, l_mrv}), 64'd0);
        mem_data_ready = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_tag = 5'h01;
        cyc();
        check("dc_not_busy_after_write", 64'(l_dcrs), 64'd0);
        mem_resp_tag = 5'h1F;
        cyc();
        check("dc_drop_high_tag", 64'(l_dcrs), 64'd0);
        mem_resp_valid = 1'b0;
        // Dropped beats must not have advanced the dc counter.
        dc_req_valid = 1'b1; dc_req_rw = 1'b0; dc_req_addr = 28'h0000040;
        cyc();
        cyc();
        check("dc_read_accept", 64'(l_dcr), 64'd1);
        dc_req_valid = 1'b0;
        pulses = 0;
        mem_resp_valid = 1'b1; mem_resp_tag = 5'h01;
        for (int j = 0; j < 4; j++) begin
            cyc();
            if (l_dcrs) pulses++;
        end
        check("dc_beats", 64'(pulses), 64'd4);
        cyc();
        check("dc_fifth_beat_dropped", 64'(l_dcrs), 64'd0);
        mem_resp_valid = 1'b0;

        // icache refill completes during a dcache write burst.
        do_reset();
        ic_req_valid = 1'b1; ic_req_addr = 28'h0000200; mem_req_ready = 1'b1;
        cyc();
        cyc();
        ic_req_valid = 1'b0;
        dc_req_valid = 1'b1; dc_req_rw = 1'b1; dc_req_addr = 28'h0000300;
        cyc();
        cyc();
        dc_req_valid = 1'b0;
        hs = 0; pulses = 0;
        dc_data_valid = 1'b1; mem_data_ready = 1'b1;
        mem_resp_valid = 1'b1; mem_resp_tag = 5'h00;
        for (int j = 0; j < 4; j++) begin
            cyc();
            if (l_ddr && dc_data_valid) hs++;
            if (l_icrs) pulses++;
        end
        check("burst_handshakes", 64'(hs), 64'd4);
        check("burst_ic_beats", 64'(pulses), 64'd4);
        cyc();
        check("burst_done_ic_idle", 64'({l_ddr, l_icrs}), 64'd0);
        clr_in();

        // Reset while a command is stalled.
        do_reset();
        ic_req_valid = 1'b1; ic_req_addr = 28'h0123456; mem_req_ready = 1'b0;
        cyc();
        #1;
        check("cmd_before_reset", 64'(mem_req_valid), 64'd1);
        #1 reset = 1'b0;
        #1;
        check("reset_mid_cmd_valid", 64'(mem_req_valid), 64'd0);
        check("reset_mid_cmd_outs", 64'(outs()), 64'd0);
        model_reset();
        ic_req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        cyc();
        check("idle_after_reset", 64'(l_mrv), 64'd0);
        ic_req_valid = 1'b1; mem_req_ready = 1'b1;
        cyc();
        check("grant_after_reset", 64'(l_mrv), 64'd0);
        cyc();
        check("cmd_after_reset", 64'({l_mrv, l_tag}), 64'({1'b1, 5'h00}));
        clr_in();

        // Randomized traffic against the model, with occasional resets.
        do_reset();
        ic_p = 1'b0; dc_p = 1'b0; dc_prw = 1'b0; ic_a = '0; dc_a = '0;
        for (int i = 0; i < 2500; i++) begin
            if (i % 600 == 599) begin
                do_reset();
                ic_p = 1'b0;
                dc_p = 1'b0;
            end
            if (!ic_p && $urandom_range(3) == 0) begin
                ic_p = 1'b1;
                ic_a = AW'($urandom);
            end
            if (!dc_p && $urandom_range(3) == 0) begin
                dc_p   = 1'b1;
                dc_a   = AW'($urandom);
                dc_prw = 1'($urandom_range(1));
            end
            ic_req_valid   = ic_p;
            ic_req_addr    = ic_a;
            dc_req_valid   = dc_p;
            dc_req_addr    = dc_a;
            dc_req_rw      = dc_prw;
            dc_data_valid  = 1'($urandom_range(1));
            mem_req_ready  = ($urandom_range(2) != 0);
            mem_data_ready = 1'($urandom_range(1));
            mem_resp_valid = ($urandom_range(2) == 0);
            mem_resp_tag   = TW'($urandom);
            hs_ic = (m_phase == 1) && !m_src && mem_req_ready;
            hs_dc = (m_phase == 1) && m_src && mem_req_ready;
            cyc();
            if (hs_ic) ic_p = 1'b0;
            if (hs_dc) dc_p = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
